// File: rtl/eu_iqueue_rr_pkg.sv
// Shared data types for the per-EU instruction queue and its round-robin
// sub-FIFO bank.
package pkg_dtypes;
    localparam int unsigned LOG2_NUM_EXEC_UNITS = 2;
    typedef logic [31:0] type_iqueue_entry;
endpackage

package eu_iqueue_rr_pkg;
    localparam int unsigned DEF_LOG2_QUEUE_LENGTH  = 4;
    localparam int unsigned DEF_LOG2_NUM_QUEUES    = 2;
    localparam int unsigned DEF_NUM_DISPATCH_LANES = 4;

    // Occupancy must hold the all-full count, hence the extra bit.
    function automatic int unsigned occ_width(input int unsigned log2_len,
                                              input int unsigned log2_nq);
        return log2_len + log2_nq + 1;
    endfunction
endpackage

// File: rtl/eu_iqueue_rr_if.sv
// Dispatch-side and issue-side signal bundle of the per-EU instruction queue.
interface eu_iqueue_rr_if #(
    parameter int unsigned L     = 4,
    parameter int unsigned OCC_W = 7
);
    pkg_dtypes::type_iqueue_entry [L-1:0]                          disp_instr_i;
    logic [L-1:0]                                                  disp_valid_i;
    logic [L-1:0][pkg_dtypes::LOG2_NUM_EXEC_UNITS-1:0]             disp_euidx_i;
    logic                                                          disp_ready_o;
    logic                                                          flush_i;
    pkg_dtypes::type_iqueue_entry                                  exec_instr_o;
    logic                                                          exec_valid_o;
    logic                                                          exec_ready_i;
    logic [OCC_W-1:0]                                              occupancy_o;

    modport master (
        output disp_instr_i, disp_valid_i, disp_euidx_i, flush_i, exec_ready_i,
        input  disp_ready_o, exec_instr_o, exec_valid_o, occupancy_o
    );

    modport slave (
        input  disp_instr_i, disp_valid_i, disp_euidx_i, flush_i, exec_ready_i,
        output disp_ready_o, exec_instr_o, exec_valid_o, occupancy_o
    );
endinterface

// File: rtl/eu_iqueue_rr_fifo.sv
// First-word-fall-through FIFO with synchronous flush; pointers carry a wrap
// bit so full and empty are distinguishable without a separate counter.
module eu_iqueue_fifo
    import pkg_dtypes::*;
    import eu_iqueue_rr_pkg::*;
#(
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_QUEUE_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  type_iqueue_entry data_i,
    input  logic             pop_i,
    output type_iqueue_entry data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

    typedef logic [LOG2_DEPTH:0] ptr_t;

    type_iqueue_entry mem_q [DEPTH];
    type_iqueue_entry mem_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                     (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
    assign data_o  = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[wr_ptr_q[LOG2_DEPTH-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale words are never visible past empty_o.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/eu_iqueue_rr.sv
// Per-EU instruction queue: filters and packs a dispatch batch, spreads it
// round-robin over NQ FWFT sub-FIFOs and issues in strict dispatch order.
module eu_iqueue_rr
    import pkg_dtypes::*;
    import eu_iqueue_rr_pkg::*;
#(
    parameter int unsigned                    LOG2_QUEUE_LENGTH  = DEF_LOG2_QUEUE_LENGTH,
    parameter int unsigned                    LOG2_NUM_QUEUES    = DEF_LOG2_NUM_QUEUES,
    parameter int unsigned                    NUM_DISPATCH_LANES = DEF_NUM_DISPATCH_LANES,
    parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX             = '0
) (
    input logic           clk,
    input logic           reset,
    eu_iqueue_rr_if.slave bus
);
    localparam int unsigned NQ    = 1 << LOG2_NUM_QUEUES;
    localparam int unsigned L     = NUM_DISPATCH_LANES;
    localparam int unsigned CNT_W = $clog2(L + 1);
    localparam int unsigned OCC_W = occ_width(LOG2_QUEUE_LENGTH, LOG2_NUM_QUEUES);

    typedef logic [LOG2_NUM_QUEUES-1:0] qptr_t;
    typedef logic [CNT_W-1:0]           cnt_t;
    typedef logic [OCC_W-1:0]           occ_t;

    // One batch must never need two slots in the same sub-FIFO.
    if (NQ < L) begin : g_bad_cfg
        $error("eu_iqueue_rr: number of sub-FIFOs must be >= dispatch lanes");
    end

    logic [L-1:0]     rel;
    cnt_t             slot [L];
    cnt_t             n_rel;
    logic [NQ-1:0]    full, empty, push, pop;
    type_iqueue_entry wdata [NQ];
    type_iqueue_entry rdata [NQ];
    qptr_t            tgt;
    qptr_t            wr_ptr_q, wr_ptr_d;
    qptr_t            rd_ptr_q, rd_ptr_d;
    occ_t             occ_q, occ_d;
    logic             disp_ready, accept, exec_valid, do_pop;

    // Prefix count gives each relevant lane its packed slot index.
    always_comb begin
        rel   = '0;
        n_rel = '0;
        for (int i = 0; i < L; i++) begin
            rel[i]  = bus.disp_valid_i[i] && (bus.disp_euidx_i[i] == EU_IDX);
            slot[i] = n_rel;
            n_rel   = n_rel + cnt_t'(rel[i]);
        end
    end

    assign disp_ready = ~|full;
    assign accept     = disp_ready && (n_rel != '0) && !bus.flush_i;
    assign exec_valid = ~empty[rd_ptr_q];
    assign do_pop     = exec_valid && bus.exec_ready_i && !bus.flush_i;

    always_comb begin
        push = '0;
        pop  = '0;
        tgt  = '0;
        for (int q = 0; q < NQ; q++) begin
            wdata[q] = '0;
        end
        for (int i = 0; i < L; i++) begin
            if (rel[i]) begin
                tgt        = wr_ptr_q + qptr_t'(slot[i]);
                push[tgt]  = accept;
                wdata[tgt] = bus.disp_instr_i[i];
            end
        end
        pop[rd_ptr_q] = do_pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + qptr_t'(n_rel);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + qptr_t'(1);
            end
            occ_d = occ_q + (accept ? occ_t'(n_rel) : occ_t'(0)) - occ_t'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_fifo
        eu_iqueue_fifo #(
            .LOG2_DEPTH (LOG2_QUEUE_LENGTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush_i (bus.flush_i),
            .push_i  (push[q]),
            .data_i  (wdata[q]),
            .pop_i   (pop[q]),
            .data_o  (rdata[q]),
            .full_o  (full[q]),
            .empty_o (empty[q])
        );
    end

    assign bus.disp_ready_o = disp_ready;
    assign bus.exec_valid_o = exec_valid;
    assign bus.exec_instr_o = exec_valid ? rdata[rd_ptr_q] : '0;
    assign bus.occupancy_o  = occ_q;
endmodule

// File: tb/tb_eu_iqueue_rr.sv
// Directed bench for eu_iqueue_rr (NQ=4, L=4, depth 16, EU_IDX=2) against a
// queue-based reference model checked on every cycle.
module tb_eu_iqueue_rr;
    import pkg_dtypes::*;

    localparam int NQ    = 4;
    localparam int L     = 4;
    localparam int DEPTH = 16;
    localparam int MY_EU = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eu_iqueue_rr_if #(.L(L), .OCC_W(7)) bus ();

    eu_iqueue_rr #(
        .LOG2_QUEUE_LENGTH  (4),
        .LOG2_NUM_QUEUES    (2),
        .NUM_DISPATCH_LANES (4),
        .EU_IDX             (2'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per sub-FIFO plus the rotating pointers.
    type_iqueue_entry m_sub [NQ][$];
    type_iqueue_entry issued [$];
    int               m_wp = 0;
    int               m_rp = 0;
    bit               m_rdy, m_pop, chk_en = 1'b0;
    int               m_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_occ();
        int s = 0;
        for (int q = 0; q < NQ; q++) s += m_sub[q].size();
        return s;
    endfunction

    function automatic bit m_ready();
        for (int q = 0; q < NQ; q++) if (m_sub[q].size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1 || bus.flush_i === 1'b1) begin
            for (int q = 0; q < NQ; q++) m_sub[q].delete();
            m_wp = 0;
            m_rp = 0;
        end else begin
            m_rdy = m_ready();
            m_pop = (m_sub[m_rp].size() > 0) && (bus.exec_ready_i === 1'b1);
            if (m_pop) issued.push_back(m_sub[m_rp].pop_front());
            m_n = 0;
            if (m_rdy) begin
                for (int i = 0; i < L; i++) begin
                    if (bus.disp_valid_i[i] === 1'b1 && int'(bus.disp_euidx_i[i]) == MY_EU) begin
                        m_sub[(m_wp + m_n) % NQ].push_back(bus.disp_instr_i[i]);
                        m_n++;
                    end
                end
            end
            m_wp = (m_wp + m_n) % NQ;
            if (m_pop) m_rp = (m_rp + 1) % NQ;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("exec_valid", bus.exec_valid_o, m_sub[m_rp].size() > 0);
            if (m_sub[m_rp].size() > 0) chk("exec_instr", bus.exec_instr_o, m_sub[m_rp][0]);
            else                        chk("exec_instr_idle", bus.exec_instr_o, 0);
            chk("disp_ready", bus.disp_ready_o, m_ready());
            chk("occupancy", bus.occupancy_o, m_occ());
        end
    end

    task automatic drive(input logic [3:0] v,
                         input logic [1:0] e0, input logic [1:0] e1,
                         input logic [1:0] e2, input logic [1:0] e3,
                         input type_iqueue_entry t0, input type_iqueue_entry t1,
                         input type_iqueue_entry t2, input type_iqueue_entry t3,
                         input logic rdy);
        bus.disp_valid_i = v;
        bus.disp_euidx_i = {e3, e2, e1, e0};
        bus.disp_instr_i = {t3, t2, t1, t0};
        bus.exec_ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        repeat (n) drive(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic single(input int idx, input type_iqueue_entry tag, input logic rdy);
        logic [3:0] v;
        v = 4'b0001 << (idx % 4);
        drive(v, 2, 2, 2, 2, tag, tag, tag, tag, rdy);
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, "_valid"}, bus.exec_valid_o, 0);
        chk({tag, "_instr"}, bus.exec_instr_o, 0);
        chk({tag, "_occ"},   bus.occupancy_o, 0);
        chk({tag, "_ready"}, bus.disp_ready_o, 1);
    endtask

    initial begin
        type_iqueue_entry exp_order [5];
        int acc;

        reset            = 1'b1;
        bus.flush_i      = 1'b0;
        bus.disp_valid_i = '0;
        bus.disp_euidx_i = '0;
        bus.disp_instr_i = '0;
        bus.exec_ready_i = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle_state("reset");

        // Test 1: lanes euidx {2,0,2,2}, tags A..D; B must be filtered out.
        drive(4'b1111, 2, 0, 2, 2, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0);
        chk("t1_occ", bus.occupancy_o, 3);
        chk("t1_head", bus.exec_instr_o, 32'hA);
        chk("t1_model_q0", m_sub[0][0], 32'hA);
        chk("t1_model_q1", m_sub[1][0], 32'hC);
        chk("t1_model_q2", m_sub[2][0], 32'hD);
        chk("t1_model_wp", m_wp, 3);
        idle(1'b1, 2);
        chk("t1_head_d", bus.exec_instr_o, 32'hD);

        // Test 2: E,F wrap from sub-FIFO 3 to 0 while D issues.
        drive(4'b1111, 2, 2, 1, 3, 32'hE, 32'hF, 32'hEE, 32'hFF, 1'b1);
        chk("t2_model_q3", m_sub[3][0], 32'hE);
        chk("t2_model_q0", m_sub[0][0], 32'hF);
        chk("t2_model_wp", m_wp, 1);
        chk("t2_occ", bus.occupancy_o, 2);
        chk("t2_head", bus.exec_instr_o, 32'hE);
        repeat (2) drive(4'b1111, 0, 1, 3, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
        chk("t2_irrel_occ", bus.occupancy_o, 2);
        chk("t2_irrel_wp", m_wp, 1);
        idle(1'b1, 3);
        chk("t2_drained", bus.occupancy_o, 0);
        exp_order = '{32'hA, 32'hC, 32'hD, 32'hE, 32'hF};
        chk("t2_issued_n", issued.size(), 5);
        for (int k = 0; k < 5 && k < issued.size(); k++) chk("t2_issue_order", issued[k], exp_order[k]);

        // Test 3: fill with single relevant lanes until backpressure.
        bus.flush_i = 1'b1;
        idle(1'b0, 1);
        bus.flush_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 64 && bus.disp_ready_o === 1'b1; i++) begin
            single(i, 32'h100 + i, 1'b0);
            acc++;
        end
        chk("t3_accepts", acc, 61);
        chk("t3_occ", bus.occupancy_o, 61);
        chk("t3_ready_low", bus.disp_ready_o, 0);

        // Test 4: hold the 62nd entry with the EU stalled.
        for (int c = 0; c < 5; c++) begin
            single(61, 32'h13D, 1'b0);
            chk("t4_hold_valid", bus.exec_valid_o, 1);
            chk("t4_hold_instr", bus.exec_instr_o, 32'h100);
            chk("t4_hold_occ", bus.occupancy_o, 61);
        end
        single(61, 32'h13D, 1'b1);
        chk("t4_pop_occ", bus.occupancy_o, 60);
        chk("t4_pop_head", bus.exec_instr_o, 32'h101);
        chk("t4_ready_back", bus.disp_ready_o, 1);
        single(61, 32'h13D, 1'b0);
        chk("t4_late_accept", bus.occupancy_o, 61);
        for (int c = 1; c <= 4; c++) begin
            idle(1'b1, 1);
            chk("t4_drain_occ", bus.occupancy_o, 61 - c);
        end
        for (int k = 0; k < 5; k++) chk("t4_issue_order", issued[5 + k], 32'h100 + k);

        // Test 5: flush during a 3-lane dispatch and a pop.
        bus.flush_i = 1'b1;
        drive(4'b0111, 2, 2, 2, 0, 32'h201, 32'h202, 32'h203, 32'h0, 1'b1);
        bus.flush_i = 1'b0;
        chk_idle_state("t5_flush");
        chk("t5_model_wp", m_wp, 0);
        drive(4'b0100, 0, 0, 2, 0, 32'h0, 32'h0, 32'h55, 32'h0, 1'b0);
        chk("t5_head", bus.exec_instr_o, 32'h55);
        chk("t5_model_q0", m_sub[0][0], 32'h55);
        idle(1'b1, 1);
        chk("t5_issued", issued[issued.size() - 1], 32'h55);

        // Test 6: reset mid-stream at occupancy 20.
        for (int c = 0; c < 5; c++)
            drive(4'b1111, 2, 2, 2, 2, 32'h300 + 4 * c, 32'h301 + 4 * c,
                  32'h302 + 4 * c, 32'h303 + 4 * c, 1'b0);
        chk("t6_occ20", bus.occupancy_o, 20);
        reset = 1'b1;
        drive(4'b1111, 2, 2, 2, 2, 32'h400, 32'h401, 32'h402, 32'h403, 1'b1);
        reset = 1'b0;
        chk_idle_state("t6_reset");
        idle(1'b1, 3);
        chk("t6_no_stale", bus.exec_valid_o, 0);
        drive(4'b0010, 0, 2, 0, 0, 32'h0, 32'h77, 32'h0, 32'h0, 1'b0);
        chk("t6_new_head", bus.exec_instr_o, 32'h77);
        idle(1'b1, 1);
        chk("t6_issued", issued[issued.size() - 1], 32'h77);
        chk("t6_empty", bus.occupancy_o, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
